// File: rtl/figo_route_sequencer.sv
// figo_route_sequencer
// Drives a Land-of-FIGO room-walker from a stored travel route, one
// travel_plan bit per clock, and reports how the walk ended.
//
// Ports:
//   clk              rising-edge clock, shared with the walker
//   reset            synchronous, active-high
//   start            one-cycle run request, honoured only while idle
//   abort            cancels the run in progress
//   route_bits       route, bit 0 applied first; latched on accepted start
//   route_len        number of route bits to apply; latched on accepted start
//   current_location room code reported by the walker
//   fsm_rst          reset to the walker (held high between runs)
//   travel_plan      step bit to the walker
//   busy             high while the walker is being stepped or drained
//   done             one-cycle pulse when a run completes
//   result           00 exhausted, 01 goal, 10 trap, 11 aborted
//   final_location   room captured when the run was decided
//   steps_taken      number of route bits whose effect was observed
module figo_route_sequencer #(
   parameter int         ROUTE_W   = 16,
   parameter int         LEN_W     = 5,
   parameter logic [2:0] GOAL_ROOM = 3'd7,
   parameter logic [2:0] TRAP_ROOM = 3'd6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [ROUTE_W-1:0] route_bits,
   input  logic [LEN_W-1:0]   route_len,
   input  logic [2:0]         current_location,
   output logic               fsm_rst,
   output logic               travel_plan,
   output logic               busy,
   output logic               done,
   output logic [1:0]         result,
   output logic [2:0]         final_location,
   output logic [LEN_W-1:0]   steps_taken
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FLUSH,
      DONE
   } state_t;

   localparam logic [1:0]       RES_EXHAUSTED = 2'b00;
   localparam logic [1:0]       RES_GOAL      = 2'b01;
   localparam logic [1:0]       RES_TRAP      = 2'b10;
   localparam logic [1:0]       RES_ABORTED   = 2'b11;
   localparam logic [LEN_W-1:0] MAX_LEN       = LEN_W'(ROUTE_W);

   state_t             state, state_next;
   logic [ROUTE_W-1:0] route_sr, route_sr_next;
   logic [LEN_W-1:0]   len, len_next;
   logic [LEN_W-1:0]   idx, idx_next;
   logic [1:0]         result_next;
   logic [2:0]         final_next;
   logic [LEN_W-1:0]   steps_next;
   logic [LEN_W-1:0]   len_clamped;
   logic               at_goal, at_trap;

   // The route is kept as a shift register so the bit for the current step
   // is always at position 0; the walker sees it straight from a flop.
   assign fsm_rst     = (state == IDLE) || (state == DONE);
   assign busy        = (state == RUN) || (state == FLUSH);
   assign done        = (state == DONE);
   assign travel_plan = (state == RUN) && route_sr[0];

   assign len_clamped = (route_len > MAX_LEN) ? MAX_LEN : route_len;
   assign at_goal     = (current_location == GOAL_ROOM);
   assign at_trap     = (current_location == TRAP_ROOM);

   // Next-state and next-register logic. The walker's location lags the
   // driven bit by one clock, so the sample taken at step idx reflects bit
   // idx-1; step 0 always sees room 0 and is ignored. Goal is tested before
   // trap so it wins if both codes coincide, and abort beats both.
   always_comb begin
      state_next    = state;
      route_sr_next = route_sr;
      len_next      = len;
      idx_next      = idx;
      result_next   = result;
      final_next    = final_location;
      steps_next    = steps_taken;

      unique case (state)
         IDLE: begin
            if (start) begin
               route_sr_next = route_bits;
               len_next      = len_clamped;
               idx_next      = '0;
               if (len_clamped == '0) begin
                  state_next  = DONE;
                  result_next = RES_EXHAUSTED;
                  final_next  = 3'd0;
                  steps_next  = '0;
               end else begin
                  state_next = RUN;
               end
            end
         end

         RUN: begin
            if (abort) begin
               state_next  = DONE;
               result_next = RES_ABORTED;
               final_next  = current_location;
               steps_next  = idx;
            end else if ((idx != '0) && at_goal) begin
               state_next  = DONE;
               result_next = RES_GOAL;
               final_next  = current_location;
               steps_next  = idx;
            end else if ((idx != '0) && at_trap) begin
               state_next  = DONE;
               result_next = RES_TRAP;
               final_next  = current_location;
               steps_next  = idx;
            end else if (idx == len - LEN_W'(1)) begin
               state_next = FLUSH;
            end else begin
               idx_next      = idx + LEN_W'(1);
               route_sr_next = route_sr >> 1;
            end
         end

         FLUSH: begin
            state_next = DONE;
            if (abort) begin
               result_next = RES_ABORTED;
               final_next  = current_location;
               steps_next  = idx;
            end else begin
               final_next = current_location;
               steps_next = len;
               if (at_goal) begin
                  result_next = RES_GOAL;
               end else if (at_trap) begin
                  result_next = RES_TRAP;
               end else begin
                  result_next = RES_EXHAUSTED;
               end
            end
         end

         DONE: begin
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State and result registers. Result, final room and step count only
   // change at the deciding edge so they stay readable after done drops.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         route_sr       <= '0;
         len            <= '0;
         idx            <= '0;
         result         <= RES_EXHAUSTED;
         final_location <= 3'd0;
         steps_taken    <= '0;
      end else begin
         state          <= state_next;
         route_sr       <= route_sr_next;
         len            <= len_next;
         idx            <= idx_next;
         result         <= result_next;
         final_location <= final_next;
         steps_taken    <= steps_next;
      end
   end

endmodule

// File: tb/tb_figo_route_sequencer.sv
// tb_figo_route_sequencer
// Directed bench for figo_route_sequencer. Two sequencers share the
// stimulus: dut0 uses the default goal room 7, dut1 has its goal room moved
// to 5. Each one drives a scripted walker stand-in whose room sequence is
// chosen per test, so expected outcomes can be worked out by hand.
module tb_figo_route_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] routeBits = '0;
   logic [4:0]  routeLen = '0;

   logic [2:0]  loc0 = '0;
   logic [2:0]  loc1 = '0;
   int          step0 = 0;
   int          step1 = 0;
   logic [31:0] log0 = '0;
   logic [31:0] log1 = '0;
   logic [2:0]  script [32];

   logic        fsmRst0, plan0, busy0, done0;
   logic [1:0]  result0;
   logic [2:0]  final0;
   logic [4:0]  steps0;
   logic        fsmRst1, plan1, busy1, done1;
   logic [1:0]  result1;
   logic [2:0]  final1;
   logic [4:0]  steps1;

   int          checkCount = 0;
   int          passCount = 0;

   figo_route_sequencer dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .route_bits(routeBits), .route_len(routeLen), .current_location(loc0),
      .fsm_rst(fsmRst0), .travel_plan(plan0), .busy(busy0), .done(done0),
      .result(result0), .final_location(final0), .steps_taken(steps0)
   );

   figo_route_sequencer #(.GOAL_ROOM(3'd5)) dut1 (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .route_bits(routeBits), .route_len(routeLen), .current_location(loc1),
      .fsm_rst(fsmRst1), .travel_plan(plan1), .busy(busy1), .done(done1),
      .result(result1), .final_location(final1), .steps_taken(steps1)
   );

   always #5 clk = ~clk;

   // Walker stand-ins: held at room 0 while their reset is high, otherwise
   // they move to the next scripted room every clock and record the
   // travel_plan bit they were given, bit n of the log being step n.
   always @(posedge clk) begin
      if (fsmRst0) begin
         loc0  <= 3'd0;
         step0 <= 0;
      end else begin
         loc0  <= (step0 < 32) ? script[step0] : 3'd0;
         step0 <= step0 + 1;
         if (step0 == 0) log0 <= 32'(plan0);
         else if (step0 < 32) log0[step0] <= plan0;
      end
   end

   always @(posedge clk) begin
      if (fsmRst1) begin
         loc1  <= 3'd0;
         step1 <= 0;
      end else begin
         loc1  <= (step1 < 32) ? script[step1] : 3'd0;
         step1 <= step1 + 1;
         if (step1 == 0) log1 <= 32'(plan1);
         else if (step1 < 32) log1[step1] <= plan1;
      end
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Loads the walker script: the first entries given, then room 0.
   task automatic loadScript(input logic [2:0] r0, input logic [2:0] r1,
                             input logic [2:0] r2, input logic [2:0] r3,
                             input logic [2:0] r4);
      for (int i = 0; i < 32; i++) script[i] = 3'd0;
      script[0] = r0; script[1] = r1; script[2] = r2; script[3] = r3; script[4] = r4;
   endtask

   // Runs one route on the selected sequencer. start is raised in cycle T;
   // each loop pass sits #1 into cycle T+k. The done pulse, busy and
   // fsm_rst are checked every cycle, the outcome in the done cycle and
   // again one cycle later to confirm it is held. abortAt/restartAt raise
   // abort or a second start (with a different route) in cycle T+k.
   task automatic applyStimulus(input string name, input bit sel,
                                input logic [15:0] bits, input logic [4:0] len,
                                input int abortAt, input int restartAt,
                                input int expDone, input logic [1:0] expResult,
                                input logic [2:0] expFinal, input logic [4:0] expSteps,
                                input bit checkLog, input logic [31:0] expLog);
      repeat (20) @(posedge clk);
      #1;
      routeBits = bits;
      routeLen  = len;
      start     = 1'b1;
      for (int k = 1; k <= expDone + 1; k++) begin
         @(posedge clk);
         #1;
         start = (k == restartAt);
         abort = (k == abortAt);
         if (k == restartAt) begin
            routeBits = 16'hFFFF;
            routeLen  = 5'd3;
         end
         checkOutput($sformatf("%s.done@T+%0d", name, k),
                     32'(sel ? done1 : done0), 32'(k == expDone));
         checkOutput($sformatf("%s.busy@T+%0d", name, k),
                     32'(sel ? busy1 : busy0), 32'(k < expDone));
         checkOutput($sformatf("%s.fsm_rst@T+%0d", name, k),
                     32'(sel ? fsmRst1 : fsmRst0), 32'(k >= expDone));
         if (k == expDone) begin
            checkOutput({name, ".result"}, 32'(sel ? result1 : result0), 32'(expResult));
            checkOutput({name, ".final"}, 32'(sel ? final1 : final0), 32'(expFinal));
            checkOutput({name, ".steps"}, 32'(sel ? steps1 : steps0), 32'(expSteps));
            checkOutput({name, ".plan_idle"}, 32'(sel ? plan1 : plan0), 32'd0);
            if (checkLog)
               checkOutput({name, ".plan_log"}, sel ? log1 : log0, expLog);
         end
         if (k == expDone + 1) begin
            checkOutput({name, ".result_held"}, 32'(sel ? result1 : result0), 32'(expResult));
            checkOutput({name, ".steps_held"}, 32'(sel ? steps1 : steps0), 32'(expSteps));
         end
      end
      start = 1'b0;
      abort = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      loadScript(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst.fsm_rst", 32'(fsmRst0), 32'd1);
      checkOutput("rst.plan", 32'(plan0), 32'd0);
      checkOutput("rst.busy", 32'(busy0), 32'd0);
      checkOutput("rst.done", 32'(done0), 32'd0);
      checkOutput("rst.result", 32'(result0), 32'd0);
      checkOutput("rst.final", 32'(final0), 32'd0);
      checkOutput("rst.steps", 32'(steps0), 32'd0);
      reset = 1'b0;

      // Walker rooms 1,2,1,7: goal seen at T+5, done at T+6.
      loadScript(3'd1, 3'd2, 3'd1, 3'd7, 3'd0);
      applyStimulus("goal", 1'b0, 16'h000F, 5'd8, 0, 0, 6, 2'b01, 3'd7, 5'd4, 1'b1, 32'h0F);

      // All-zero route stays in room 0; run exhausts after the flush.
      loadScript(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      applyStimulus("exhaust", 1'b0, 16'h0000, 5'd3, 0, 0, 5, 2'b00, 3'd0, 5'd3, 1'b1, 32'h0);

      // Zero length finishes immediately without ever going busy.
      applyStimulus("len0", 1'b0, 16'hFFFF, 5'd0, 0, 0, 1, 2'b00, 3'd0, 5'd0, 1'b0, 32'h0);

      // Length 20 is clamped to 16; rooms cycle 0..5 so nothing is hit.
      for (int i = 0; i < 32; i++) script[i] = 3'(i % 6);
      applyStimulus("clamp", 1'b0, 16'hA5C3, 5'd20, 0, 0, 18, 2'b00, 3'd3, 5'd16, 1'b1, 32'h0A5C3);

      // Goal moved to 5: room 7 passes, room 6 is a trap at step 5.
      loadScript(3'd1, 3'd2, 3'd3, 3'd7, 3'd6);
      applyStimulus("trap", 1'b1, 16'h000F, 5'd6, 0, 0, 7, 2'b10, 3'd6, 5'd5, 1'b1, 32'h0F);

      // Abort at T+3 wins; the start at T+2 must not reload the route.
      loadScript(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      applyStimulus("abort", 1'b0, 16'h0001, 5'd10, 3, 2, 4, 2'b11, 3'd0, 5'd2, 1'b1, 32'h1);

      // Reset in the middle of a run returns everything to reset values.
      loadScript(3'd1, 3'd2, 3'd1, 3'd7, 3'd0);
      repeat (20) @(posedge clk);
      #1;
      routeBits = 16'h000F;
      routeLen  = 5'd8;
      start     = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("midrst.busy_before", 32'(busy0), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("midrst.busy", 32'(busy0), 32'd0);
      checkOutput("midrst.fsm_rst", 32'(fsmRst0), 32'd1);
      checkOutput("midrst.plan", 32'(plan0), 32'd0);
      checkOutput("midrst.result", 32'(result0), 32'd0);
      checkOutput("midrst.steps", 32'(steps0), 32'd0);
      checkOutput("midrst.done", 32'(done0), 32'd0);

      loadScript(3'd0, 3'd0, 3'd0, 3'd0, 3'd0);
      applyStimulus("rerun", 1'b0, 16'h0000, 5'd3, 0, 0, 5, 2'b00, 3'd0, 5'd3, 1'b1, 32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
